rng_check: RTL and testbench

//  Receive-side checker for the rtt_probe pseudo-random payload. Self-synchronises
//  a local 64-bit LFSR (taps 63^62^60^59, shift-left, feedback into bit 0) to the

---
 rtl/rng_check_pkg.sv | 30 +++
 rtl/rng_check_lfsr64_step.sv | 39 +++
 rtl/rng_check.sv | 158 +++++++++++++++
 tb/tb_rng_check.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_check_pkg.sv
// ============================================================================
//  Module      : rng_check_pkg
//  Description : Shared rtt_probe PRNG definitions: LFSR width, taps, step fn.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package rng_check_pkg;

    localparam int c_LFSR_W = 64;
    localparam int c_TAP_A  = 63;
    localparam int c_TAP_B  = 62;
    localparam int c_TAP_C  = 60;
    localparam int c_TAP_D  = 59;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_ADV  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // One shift-left step; the XOR of the taps feeds bit 0.
    function automatic logic [c_LFSR_W-1:0] lfsr_step(input logic [c_LFSR_W-1:0] v);
        return {v[c_LFSR_W-2:0], v[c_TAP_A] ^ v[c_TAP_B] ^ v[c_TAP_C] ^ v[c_TAP_D]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rng_check_lfsr64_step.sv
// ============================================================================
//  Module      : lfsr64_step
//  Description : 64-bit LFSR register with load, shift enable and a zero
//                detect on the load candidate.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module lfsr64_step
    import rng_check_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [c_LFSR_W-1:0] load_val,
    input  logic                shift,
    output logic [c_LFSR_W-1:0] value,
    output logic                load_val_zero
);

    logic [c_LFSR_W-1:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= '0;
        end else if (load) begin
            r_lfsr <= load_val;
        end else if (shift) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign value         = r_lfsr;
    // All-zero is the lock-up value and must never be loaded as a seed.
    assign load_val_zero = (load_val == '0);

endmodule

`default_nettype wire

// File: rtl/rng_check.sv
// ============================================================================
//  Module      : rng_check
//  Description : Receive-side PRNG payload checker; self-syncs a local LFSR
//                and counts good/bad words. Option: RNG_CHECK_RESYNC_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rng_check
    import rng_check_pkg::*;
#(
    parameter int STEPS = 64,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clr_cnt,
    input  logic [c_LFSR_W-1:0] in_data,
    input  logic                in_vld,
    output logic                in_rdy,
    output logic                locked,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    word_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int                  c_STEP_W    = $clog2(STEPS) + 1;
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(STEPS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_STEP_W-1:0] r_step;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_err_pulse;

    logic                w_accept;
    logic                w_match;
    logic                w_data_zero;
    logic                w_load;
    logic                w_shift;
    logic                w_word_inc;
    logic                w_err_inc;
    logic [c_LFSR_W-1:0] w_lfsr;

    lfsr64_step u_lfsr (
        .clk           (clk),
        .reset         (reset),
        .load          (w_load),
        .load_val      (in_data),
        .shift         (w_shift),
        .value         (w_lfsr),
        .load_val_zero (w_data_zero)
    );

    assign in_rdy   = (r_state != ST_ADV);
    assign w_accept = in_vld && in_rdy;
    assign w_match  = (in_data == w_lfsr);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_word_inc  = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_SYNC: begin
                if (w_accept && !w_data_zero) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ADV;
                end
            end
            ST_ADV: begin
                w_shift = 1'b1;
                if (r_step == c_LAST_STEP) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_accept) begin
                    if (w_match) begin
                        w_word_inc  = 1'b1;
                        w_state_nxt = ST_ADV;
                    end else begin
                        w_err_inc = 1'b1;
`ifdef RNG_CHECK_RESYNC_EN
                        if (w_data_zero) begin
                            w_state_nxt = ST_SYNC;
                        end else begin
                            w_load      = 1'b1;
                            w_state_nxt = ST_ADV;
                        end
`else
                        w_state_nxt = ST_ADV;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // start overrides everything, including a word accepted this cycle.
        if (start) begin
            w_state_nxt = ST_SYNC;
            w_load      = 1'b0;
            w_word_inc  = 1'b0;
            w_err_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ADV) begin
                r_step <= r_step + c_STEP_W'(1);
            end else begin
                r_step <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word_cnt  <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err_inc;
            if (clr_cnt) begin
                r_word_cnt <= '0;
                r_err_cnt  <= '0;
            end else begin
                if (w_word_inc && !(&r_word_cnt)) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
                if (w_err_inc && !(&r_err_cnt)) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign locked    = (r_state == ST_ADV) || (r_state == ST_WAIT);
    assign err_pulse = r_err_pulse;
    assign word_cnt  = r_word_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rng_check.sv
// ============================================================================
//  Module      : tb_rng_check
//  Description : Self-checking bench for rng_check (table-driven streams plus
//                hand-written corner sequences). Honours RNG_CHECK_RESYNC_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rng_check;

    localparam logic [63:0] c_SEED = 64'h0123_4567_89AB_CDEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic        locked;
    logic        err_pulse;
    logic [31:0] word_cnt;
    logic [31:0] err_cnt;

    int checks = 0;
    int failures = 0;
    logic exp_q[$];

    rng_check #(.STEPS(64), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .clr_cnt   (clr_cnt),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .locked    (locked),
        .err_pulse (err_pulse),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n_words;
        int          bad_idx;
        logic [63:0] mask;
        logic [63:0] seed;
        logic [31:0] exp_word;
        logic [31:0] exp_err;
    } vec_t;

    vec_t vecs[3];

    function automatic logic [63:0] m_adv(input logic [63:0] v);
        logic [63:0] x;
        x = v;
        for (int i = 0; i < 64; i++) begin
            x = {x[62:0], x[63] ^ x[62] ^ x[60] ^ x[59]};
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer a word, wait for acceptance, then compare err_pulse with the queue head.
    task automatic send(input logic [63:0] d, input logic clr, output int stall);
        logic exp_e;
        stall   = 0;
        in_data = d;
        in_vld  = 1'b1;
        while (!in_rdy && stall < 200) begin
            @(negedge clk);
            stall++;
        end
        if (!in_rdy) begin
            chk("accept_timeout", 64'(stall), 64'd64);
            in_vld = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        clr_cnt = clr;
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        clr_cnt = 1'b0;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            exp_e = exp_q.pop_front();
            chk("err_pulse", 64'(err_pulse), 64'(exp_e));
        end
    endtask

    initial begin
        int          st;
        logic [63:0] w;
        logic [63:0] tx;
        logic        e;
        int          guard;

`ifdef RNG_CHECK_RESYNC_EN
        vecs[0] = '{20, -1, 64'h0, c_SEED, 32'd19, 32'd0};
        vecs[1] = '{20, 5, 64'h1, c_SEED, 32'd17, 32'd2};
        vecs[2] = '{12, 8, 64'hFFFF_0000_0000_0000, 64'hDEAD_BEEF_0000_0001, 32'd9, 32'd2};
`else
        vecs[0] = '{20, -1, 64'h0, c_SEED, 32'd19, 32'd0};
        vecs[1] = '{20, 5, 64'h1, c_SEED, 32'd18, 32'd1};
        vecs[2] = '{12, 8, 64'hFFFF_0000_0000_0000, 64'hDEAD_BEEF_0000_0001, 32'd10, 32'd1};
`endif

        @(negedge clk);
        do_reset();
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_err_pulse", 64'(err_pulse), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_in_rdy_idle", 64'(in_rdy), 64'd1);

        // Table-driven streams
        for (int v = 0; v < 3; v++) begin
            do_reset();
            do_start();
            chk("sync_locked", 64'(locked), 64'd0);
            w = vecs[v].seed;
            for (int k = 0; k < vecs[v].n_words; k++) begin
                tx = (k == vecs[v].bad_idx) ? (w ^ vecs[v].mask) : w;
`ifdef RNG_CHECK_RESYNC_EN
                e = (k >= 1) && (k == vecs[v].bad_idx || (vecs[v].bad_idx >= 1 && k == vecs[v].bad_idx + 1));
`else
                e = (k >= 1) && (k == vecs[v].bad_idx);
`endif
                exp_q.push_back(e);
                send(tx, 1'b0, st);
                if (k == 0) chk("locked_after_first", 64'(locked), 64'd1);
                else        chk("rdy_low_cycles", 64'(st), 64'd64);
                w = m_adv(w);
            end
            chk("vec_word_cnt", 64'(word_cnt), 64'(vecs[v].exp_word));
            chk("vec_err_cnt", 64'(err_cnt), 64'(vecs[v].exp_err));
        end

        // Zero offered in SYNC is discarded; lock on 0x1
        do_reset();
        do_start();
        exp_q.push_back(1'b0);
        send(64'h0, 1'b0, st);
        chk("zero_not_locked", 64'(locked), 64'd0);
        exp_q.push_back(1'b0);
        send(64'h1, 1'b0, st);
        chk("one_no_stall", 64'(st), 64'd0);
        chk("one_locked", 64'(locked), 64'd1);
        exp_q.push_back(1'b0);
        send(m_adv(64'h1), 1'b0, st);
        chk("one_next_good", 64'(word_cnt), 64'd1);
        exp_q.push_back(1'b1);
        send(m_adv(m_adv(64'h1)) ^ 64'h8000_0000_0000_0000, 1'b0, st);
        chk("one_next_bad", 64'(err_cnt), 64'd1);

        // clr_cnt with a same-cycle good accept
        do_reset();
        do_start();
        w = c_SEED;
        exp_q.push_back(1'b0);
        send(w, 1'b0, st);
        w = m_adv(w);
        exp_q.push_back(1'b0);
        send(w, 1'b0, st);
        chk("pre_clr_word_cnt", 64'(word_cnt), 64'd1);
        w = m_adv(w);
        exp_q.push_back(1'b0);
        send(w, 1'b1, st);
        chk("clr_wins_word_cnt", 64'(word_cnt), 64'd0);
        w = m_adv(w);
        exp_q.push_back(1'b0);
        send(w, 1'b0, st);
        chk("post_clr_word_cnt", 64'(word_cnt), 64'd1);

        // Error counter saturation from a preloaded value
        force dut.r_err_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_err_cnt;
        @(negedge clk);
        chk("preload_err_cnt", 64'(err_cnt), 64'h0000_0000_FFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            w = m_adv(w);
            exp_q.push_back(1'b1);
            send(~w, 1'b0, st);
        end
        chk("sat_err_cnt", 64'(err_cnt), 64'h0000_0000_FFFF_FFFF);
        chk("sat_word_cnt_kept", 64'(word_cnt), 64'd1);

        // start mid-ADV, then re-lock on a fresh stream
        do_reset();
        do_start();
        w = c_SEED;
        exp_q.push_back(1'b0);
        send(w, 1'b0, st);
        w = m_adv(w);
        exp_q.push_back(1'b0);
        send(w, 1'b0, st);
        repeat (10) @(negedge clk);
        do_start();
        chk("restart_unlocked", 64'(locked), 64'd0);
        chk("restart_word_cnt", 64'(word_cnt), 64'd1);
        w = 64'h0BAD_CAFE_1234_5678;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(1'b0);
            send(w, 1'b0, st);
            if (k == 0) chk("restart_no_stall", 64'(st), 64'd0);
            w = m_adv(w);
        end
        chk("relock_locked", 64'(locked), 64'd1);
        chk("relock_word_cnt", 64'(word_cnt), 64'd3);
        chk("relock_err_cnt", 64'(err_cnt), 64'd0);

        // start with a simultaneous accept in WAIT: word discarded
        guard = 0;
        while (!in_rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_reached", 64'(in_rdy), 64'd1);
        in_data = ~w;
        in_vld  = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        in_vld  = 1'b0;
        start   = 1'b0;
        chk("start_wins_locked", 64'(locked), 64'd0);
        chk("start_wins_err_pulse", 64'(err_pulse), 64'd0);
        chk("start_wins_err_cnt", 64'(err_cnt), 64'd0);

        // reset mid-ADV
        exp_q.push_back(1'b0);
        send(c_SEED, 1'b0, st);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_locked", 64'(locked), 64'd0);
        chk("midrst_err_pulse", 64'(err_pulse), 64'd0);
        chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
        chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
        chk("midrst_in_rdy", 64'(in_rdy), 64'd1);
        exp_q.push_back(1'b0);
        send(c_SEED, 1'b0, st);
        chk("idle_discard_locked", 64'(locked), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
